// File: rtl/clk_prescaler.sv
// clk_prescaler: free-running 2^N clock divider with a terminal-count strobe
module clk_prescaler #(
    parameter int N = 16
) (
    input  logic clk,
    input  logic reset,
    output logic out,
    output logic tick
);
    logic [N-1:0] r_count;
    // Free-running counter; cleared immediately on reset, wraps modulo 2^N
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_count <= '0;
        else       r_count <= r_count + N'(1);
    end
    assign out  = r_count[N-1];
    assign tick = &r_count;
endmodule

// File: tb/tb_clk_prescaler.sv
// tb_clk_prescaler: scoreboard bench checking N=4, N=1 and N=16 prescalers against an edge-count model
module tb_clk_prescaler;
    typedef struct packed {
        logic o4, t4, o1, t1, o16, t16;
    } exp_t;

    logic clk = 1'b0;
    logic rst4, rst1, rst16;
    logic o4, t4, o1, t1, o16, t16;
    int   k4, k1, k16;
    int   tests = 0;
    int   fails = 0;
    int   n_tick16 = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    clk_prescaler #(.N(4))  u4  (.clk(clk), .reset(rst4),  .out(o4),  .tick(t4));
    clk_prescaler #(.N(1))  u1  (.clk(clk), .reset(rst1),  .out(o1),  .tick(t1));
    clk_prescaler #(.N(16)) u16 (.clk(clk), .reset(rst16), .out(o16), .tick(t16));

    // Reference: after k edges out of reset the counter holds k mod 2^n
    function automatic logic m_out(input int k, input int n);
        return (k % (1 << n)) >= (1 << (n - 1));
    endfunction

    function automatic logic m_tick(input int k, input int n);
        return (k % (1 << n)) == (1 << n) - 1;
    endfunction

    task automatic chk(input string nm, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b at %0t", nm, act, req, $time);
        end
    endtask

    // One clock edge: advance the models, then optionally change the N=4 reset
    task automatic step(input logic r4n);
        @(posedge clk);
        #1;
        k4  = rst4  ? 0 : k4 + 1;
        k1  = rst1  ? 0 : k1 + 1;
        k16 = rst16 ? 0 : k16 + 1;
        if (r4n && !rst4) begin
            rst4 = 1'b1;
            k4   = 0;
            #1;
            chk("async_rst_out4", o4, 1'b0);
            chk("async_rst_tick4", t4, 1'b0);
        end else begin
            rst4 = r4n;
        end
        sb.push_back('{m_out(k4, 4), m_tick(k4, 4), m_out(k1, 1), m_tick(k1, 1),
                       m_out(k16, 16), m_tick(k16, 16)});
    endtask

    // Monitor: compare every output against the queued expectation mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("out4", o4, e.o4);
            chk("tick4", t4, e.t4);
            chk("out1", o1, e.o1);
            chk("tick1", t1, e.t1);
            chk("out16", o16, e.o16);
            chk("tick16", t16, e.t16);
            if (t16 === 1'b1) n_tick16++;
        end
    end

    initial begin
        rst4 = 1'b1; rst1 = 1'b1; rst16 = 1'b1;
        k4 = 0; k1 = 0; k16 = 0;
        repeat (5) step(1'b1);
        rst4 = 1'b0; rst1 = 1'b0; rst16 = 1'b0;
        repeat (48) step(1'b0);
        repeat (10) step(1'b0);
        step(1'b1);
        step(1'b0);
        while (k16 < 65540)
            step(($urandom_range(0, 15) == 0) ? ~rst4 : rst4);
        repeat (2) @(negedge clk);
        tests++;
        if (n_tick16 != 1) begin
            fails++;
            $display("FAIL tick16_count: got %0d, required 1", n_tick16);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/clk_prescaler.md
Name: clk_prescaler

Overview:
- Free-running binary clock divider. Divides the system clock by 2^N and produces a 50 %-duty divided clock.
- Also produces a one-cycle wrap strobe in the system-clock domain.
- Used by I/O blocks to derive slow scan clocks, e.g. the 7-segment digit multiplex clock: N=16 gives roughly 1.5 kHz from 100 MHz.
- Pure counter logic, no bus interface.

Parameters:
- N, 16, counter width. The divide ratio is 2^N. Legal range 1..32.

Ports:
- clk, input, 1, system clock. All state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- out, output, 1, divided clock = counter MSB. Period 2^N clk cycles, high for 2^(N-1).
- tick, output, 1, high for exactly one clk cycle while the counter holds 2^N-1 (the last cycle before wrap).

Behaviour:
- Internal register count[N-1:0].
  - On reset assertion: count is 0 immediately, with no clock required.
  - While reset is high: count holds 0.
- On each rising clk edge with reset low: count <= count + 1, modulo 2^N.
  - 2^N-1 wraps to 0.
  - No saturation, no enable, no load.
- out = count[N-1].
  - It is driven directly from the flop, with no combinational logic, so it is glitch-free and safe to use as a clock.
  - Reset value 0.
- tick = (count == 2^N-1). Decoded combinationally from count.
  - Reset value 0. (For N=1 the reset value of out is 0 and of tick is 0.)
  - tick is used only as a synchronous enable in the clk domain, never as a clock.
- Timing after reset release, with edges counted from the first rising clk edge after release:
  - After k edges, count = k mod 2^N.
  - out first rises after edge 2^(N-1) and first falls after edge 2^N.
  - tick is high between edges 2^N-1 and 2^N, then repeats every 2^N cycles.
- N=1 case: out toggles every clk edge, and tick equals out.
- Reset asserted mid-period:
  - out and tick are forced to 0 asynchronously. A truncated high pulse on out is acceptable.
  - Counting restarts from 0 on the first edge after release.
- Reset release is synchronised by the integrating top level. This block adds no synchroniser.
- No X-propagation: every flop has a reset value.

Decomposition:
- No shared package needed. N is the only constant and is local to the instance.
- Single flat module with no sub-modules; counter, MSB tap and terminal-count decode all live in one always block plus an assign.

Test Plan:
- Reset hold: N=4, hold reset for 5 edges -> count=0, out=0, tick=0 throughout.
- Divide ratio: N=4, release reset, run 48 edges.
  - out is low during edges 0-7 and high during edges 8-15.
  - 3 full periods of 16 cycles, exactly 8 high each.
- Tick strobe: N=4.
  - tick is high only after edge 15, 31 and 47, each for exactly one cycle.
  - Each tick is coincident with the last high cycle of out.
- Async reset mid-count: N=4, assert reset between edges, after 11 edges (count=11, out=1).
  - out drops to 0 before the next edge, with no clock.
  - After release, out rises after edge 8 again.
- Minimum width: N=1 -> out toggles every edge (0,1,0,1…) and tick mirrors out.
- Default width: N=16, run 2^17 edges -> out rising edges are exactly 65536 cycles apart, and 2 ticks are seen.
